// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory arbiter and its lane steering logic.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // Bit positions inside the one-hot CPU access-size field; all-zero means word.
  localparam int SZ_LB  = 3;
  localparam int SZ_LBU = 2;
  localparam int SZ_LH  = 1;
  localparam int SZ_LHU = 0;

  function automatic logic size_is_byte(input logic [3:0] size);
    return size[SZ_LB] | size[SZ_LBU];
  endfunction

  function automatic logic size_is_half(input logic [3:0] size);
    return size[SZ_LH] | size[SZ_LHU];
  endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane steering: store-data replication with byte enables, and
// load-data shift with sign/zero extension for sub-word accesses.
module lane_align
  import mem_pkg::*;
(
  input  logic [3:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0.
  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  // Store side: replicate the low-aligned data onto every lane the size can hit.
  always_comb begin
    be_o    = 4'hF;
    wdata_o = wdata_i;
    if (size_is_byte(size_i)) begin
      be_o    = 4'b0001 << addr_lo_i;
      wdata_o = {4{wdata_i[7:0]}};
    end else if (size_is_half(size_i)) begin
      be_o    = 4'b0011 << addr_lo_i;
      wdata_o = {2{wdata_i[15:0]}};
    end
  end

  // Load side: extend the shifted data according to the signedness of the size.
  always_comb begin
    rdata_o = shifted;
    if (size_i[SZ_LB]) begin
      rdata_o = {{24{shifted[7]}}, shifted[7:0]};
    end else if (size_i[SZ_LBU]) begin
      rdata_o = {24'h0, shifted[7:0]};
    end else if (size_i[SZ_LH]) begin
      rdata_o = {{16{shifted[15]}}, shifted[15:0]};
    end else if (size_i[SZ_LHU]) begin
      rdata_o = {16'h0, shifted[15:0]};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU control sequencer and the debug
// loader port: round-robin grant on contention, programmable wait states,
// sub-word lane steering and CPU range/alignment fault reporting.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_LIMIT  = 32'h80000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_fault,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_grant_q, last_grant_d;
  owner_t      grant;
  logic        we_q, we_d;
  logic        fault_q, fault_d;
  logic [3:0]  size_q, size_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  logic        cpu_bad;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        unused_dbg_lo;

  // Debug accesses are word-only, so its low address bits carry no meaning.
  assign unused_dbg_lo = ^dbg_addr[1:0];

  // Out-of-range or misaligned CPU requests are answered without touching RAM.
  assign cpu_bad = (cpu_addr > ADDR_LIMIT)
                || ((cpu_size == 4'b0000) && (cpu_addr[1:0] != 2'b00))
                || (size_is_half(cpu_size) && cpu_addr[0]);

  lane_align u_lane_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  // Pick a requester; on a tie the one that did not win last time goes first.
  always_comb begin
    grant = OWN_CPU;
    if (cpu_req && dbg_req) begin
      grant = (last_grant_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (dbg_req) begin
      grant = OWN_DBG;
    end
  end

  // Next-state logic: latch the granted request, count wait states, respond.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    fault_d      = fault_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = grant;
          cnt_d   = WAIT_CNT;
          if (grant == OWN_CPU) begin
            we_d    = cpu_we;
            size_d  = cpu_size;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            fault_d = cpu_bad;
          end else begin
            we_d    = dbg_we;
            size_d  = 4'b0000;
            addr_d  = {dbg_addr[31:2], 2'b00};
            wdata_d = dbg_wdata;
            fault_d = 1'b0;
          end
          if ((grant == OWN_CPU) && cpu_bad) begin
            state_d     = RESP;
            cpu_rdata_d = 32'h0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q == OWN_CPU) begin
              cpu_rdata_d = lane_rdata;
            end else begin
              dbg_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_DBG;
      we_q         <= 1'b0;
      fault_q      <= 1'b0;
      size_q       <= 4'b0000;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      cpu_rdata_q  <= 32'h0;
      dbg_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      fault_q      <= fault_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // RAM strobes are driven only while an access is in flight.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (state_q == ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_be    = lane_be;
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_wdata = lane_wdata;
    end
  end

  assign cpu_ready = (state_q == RESP) && (owner_q == OWN_CPU);
  assign cpu_fault = cpu_ready && fault_q;
  assign dbg_ready = (state_q == RESP) && (owner_q == OWN_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle
// output comparison, directed scenarios with literal expectations, and
// randomized concurrent CPU/debug traffic.
module tb_mem_arbiter;

  localparam int          W     = 1;
  localparam logic [31:0] LIMIT = 32'h80000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0]  cpu_size = 4'h0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_fault;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
  logic [31:0] dbg_rdata;
  logic        dbg_ready;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.WAIT_STATES(W), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_fault(cpu_fault),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_init(input int i);
    return 32'(i) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // ---------------- RAM macro stand-in ----------------
  logic [31:0] ram [256];
  logic        init_ram = 1'b1;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'h0;
  logic [31:0] poke_val = 32'h0;

  assign mem_rdata = ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
    end else if (poke_en) begin
      ram[poke_idx] <= poke_val;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- observation counters ----------------
  int          men_cnt = 0;
  int          dbg_rdy_cnt = 0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wd = 32'h0;

  always @(negedge clk) begin
    if (mem_en) men_cnt <= men_cnt + 1;
    if (dbg_ready) dbg_rdy_cnt <= dbg_rdy_cnt + 1;
    if (mem_en && mem_we) begin
      last_be <= mem_be;
      last_wd <= mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] shadow [256];
  bit          m_active = 1'b0;
  bit          m_own_dbg = 1'b0;
  bit          m_last_dbg = 1'b1;
  bit          m_we = 1'b0, m_fault = 1'b0;
  logic [3:0]  m_size = 4'h0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  int          m_acc_s = 0, m_acc_e = 0, m_resp = 0;
  logic [31:0] exp_cpu_rdata = 32'h0, exp_dbg_rdata = 32'h0;

  function automatic bit is_byte(input logic [3:0] s); return s[3] | s[2]; endfunction
  function automatic bit is_half(input logic [3:0] s); return s[1] | s[0]; endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] s, input logic [1:0] a);
    if (is_byte(s)) return 4'b0001 << a;
    if (is_half(s)) return 4'b0011 << a;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wrep(input logic [3:0] s, input logic [31:0] d);
    if (is_byte(s)) return {4{d[7:0]}};
    if (is_half(s)) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] s, input logic [31:0] a);
    logic [31:0] w;
    w = shadow[a[9:2]] >> (8 * int'(a[1:0]));
    if (s[3]) return {{24{w[7]}}, w[7:0]};
    if (s[2]) return {24'h0, w[7:0]};
    if (s[1]) return {{16{w[15]}}, w[15:0]};
    if (s[0]) return {16'h0, w[15:0]};
    return w;
  endfunction

  always @(negedge clk) begin : model_p
    bit          in_acc;
    bit          in_resp;
    int          base;
    logic [31:0] w;
    if (init_ram) begin
      for (int i = 0; i < 256; i++) shadow[i] = ram_init(i);
    end else if (poke_en) begin
      shadow[poke_idx] = poke_val;
    end
    in_acc  = m_active && !m_fault && (cyc >= m_acc_s) && (cyc <= m_acc_e);
    in_resp = m_active && (cyc == m_resp);
    if (in_resp) begin
      if (!m_own_dbg && m_fault) begin
        exp_cpu_rdata = 32'h0;
      end else if (!m_we) begin
        if (m_own_dbg) exp_dbg_rdata = shadow[m_addr[9:2]];
        else           exp_cpu_rdata = load_val(m_size, m_addr);
      end else begin
        base = 8 * int'(m_addr[1:0]);
        w = shadow[m_addr[9:2]];
        if (is_byte(m_size))      w[base +: 8]  = m_wdata[7:0];
        else if (is_half(m_size)) w[base +: 16] = m_wdata[15:0];
        else                      w = m_wdata;
        shadow[m_addr[9:2]] = w;
      end
    end
    chk("mem_en", mem_en, in_acc);
    chk("mem_we", mem_we, in_acc && m_we);
    if (in_acc) begin
      chk("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
      chk("mem_be", mem_be, exp_be(m_size, m_addr[1:0]));
      chk("mem_wdata", mem_wdata, exp_wrep(m_size, m_wdata));
    end
    chk("cpu_ready", cpu_ready, in_resp && !m_own_dbg);
    chk("cpu_fault", cpu_fault, in_resp && !m_own_dbg && m_fault);
    chk("dbg_ready", dbg_ready, in_resp && m_own_dbg);
    chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    chk("dbg_rdata", dbg_rdata, exp_dbg_rdata);
    if (reset) begin
      m_active      = 1'b0;
      m_last_dbg    = 1'b1;
      exp_cpu_rdata = 32'h0;
      exp_dbg_rdata = 32'h0;
    end else if (in_resp) begin
      m_last_dbg = m_own_dbg;
      m_active   = 1'b0;
    end else if (!m_active && (cpu_req || dbg_req)) begin
      m_own_dbg = (cpu_req && dbg_req) ? !m_last_dbg : dbg_req;
      if (m_own_dbg) begin
        m_we = dbg_we; m_size = 4'h0; m_addr = dbg_addr; m_wdata = dbg_wdata; m_fault = 1'b0;
      end else begin
        m_we = cpu_we; m_size = cpu_size; m_addr = cpu_addr; m_wdata = cpu_wdata;
        m_fault = (cpu_addr > LIMIT) || ((cpu_size == 4'h0) && (cpu_addr[1:0] != 2'b00))
               || (is_half(cpu_size) && cpu_addr[0]);
      end
      m_acc_s  = cyc + 1;
      m_acc_e  = cyc + 1 + W;
      m_resp   = m_fault ? cyc + 1 : cyc + W + 2;
      m_active = 1'b1;
    end
  end

  // ---------------- requester drivers ----------------
  task automatic set_word(input logic [7:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    poke_idx = idx; poke_val = val; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic cpu_txn(input bit we, input logic [3:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int done, output bit flt);
    int t0, n;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = d;
    t0 = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ready && n < 60);
    chk("cpu_ready_timeout", cpu_ready, 1'b1);
    lat = cyc - t0; done = cyc; flt = cpu_fault;
    $display("cpu txn we=%0d size=%b addr=%h wdata=%h rdata=%h fault=%0d lat=%0d",
             we, sz, a, d, cpu_rdata, flt, lat);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic dbg_txn(input bit we, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int done);
    int t0, n;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    t0 = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!dbg_ready && n < 60);
    chk("dbg_ready_timeout", dbg_ready, 1'b1);
    lat = cyc - t0; done = cyc;
    $display("dbg txn we=%0d addr=%h wdata=%h rdata=%h lat=%0d", we, a, d, dbg_rdata, lat);
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  logic [3:0] sizes [5] = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1};

  task automatic cpu_random(input int n);
    int lat, done, k;
    bit flt;
    logic [3:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      sz = sizes[$urandom_range(0, 4)];
      k  = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 1023));
      if (k == 0)      a = LIMIT + 32'($urandom_range(1, 64));
      else if (k == 2) a = LIMIT;
      else if (k > 2) begin
        if (is_half(sz)) a[0] = 1'b0;
        else if (sz == 4'h0) a[1:0] = 2'b00;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      cpu_txn(1'($urandom_range(0, 1)), sz, a, $urandom, lat, done, flt);
    end
  endtask

  task automatic dbg_random(input int n);
    int lat, done;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      dbg_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom, lat, done);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, lat2, done_c, done_d, snap;
    bit flt;

    @(posedge clk); @(negedge clk); #1;
    init_ram = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_dbg_ready", dbg_ready, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);

    // Word load with one wait state.
    set_word(8'h40, 32'hDEADBEEF);
    snap = men_cnt;
    cpu_txn(1'b0, 4'h0, 32'h100, 32'h0, lat, done_c, flt);
    chk("lw_latency", lat, 3);
    chk("lw_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("lw_mem_en_cycles", men_cnt - snap, 2);

    // Sub-word loads.
    set_word(8'h40, 32'h80112233);
    cpu_txn(1'b0, 4'h8, 32'h103, 32'h0, lat, done_c, flt);
    chk("lb_rdata", cpu_rdata, 32'hFFFFFF80);
    cpu_txn(1'b0, 4'h4, 32'h103, 32'h0, lat, done_c, flt);
    chk("lbu_rdata", cpu_rdata, 32'h00000080);
    cpu_txn(1'b0, 4'h2, 32'h102, 32'h0, lat, done_c, flt);
    chk("lh_rdata", cpu_rdata, 32'hFFFF8011);

    // Sub-word stores and their effect on the RAM word.
    cpu_txn(1'b1, 4'h8, 32'h101, 32'h000000AB, lat, done_c, flt);
    chk("sb_be", last_be, 4'b0010);
    chk("sb_wdata", last_wd, 32'hABABABAB);
    cpu_txn(1'b1, 4'h2, 32'h102, 32'h00001234, lat, done_c, flt);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wd, 32'h12341234);
    cpu_txn(1'b0, 4'h0, 32'h100, 32'h0, lat, done_c, flt);
    chk("lw_after_stores", cpu_rdata, 32'h1234AB33);
    dbg_txn(1'b0, 32'h103, 32'h0, lat, done_d);
    chk("dbg_lowbits_ignored", dbg_rdata, 32'h1234AB33);

    // Ties: CPU first, then debug, twice.
    for (int r = 0; r < 2; r++) begin
      fork
        cpu_txn(1'b0, 4'h0, 32'h100, 32'h0, lat, done_c, flt);
        dbg_txn(1'b0, 32'h104, 32'h0, lat2, done_d);
      join
      chk("tie_cpu_first", done_c < done_d, 1'b1);
      chk("tie_cpu_latency", lat, 3);
      chk("tie_dbg_latency", lat2, 7);
    end

    // Faults: out of range, misaligned word, misaligned half; boundary is legal.
    snap = men_cnt;
    cpu_txn(1'b0, 4'h0, 32'h80004, 32'h0, lat, done_c, flt);
    chk("range_fault", flt, 1'b1);
    chk("range_fault_latency", lat, 1);
    chk("range_fault_rdata", cpu_rdata, 32'h0);
    cpu_txn(1'b1, 4'h0, 32'h102, 32'h55555555, lat, done_c, flt);
    chk("sw_align_fault", flt, 1'b1);
    chk("sw_align_latency", lat, 1);
    cpu_txn(1'b0, 4'h1, 32'h101, 32'h0, lat, done_c, flt);
    chk("lhu_align_fault", flt, 1'b1);
    chk("fault_no_mem_en", men_cnt - snap, 0);
    cpu_txn(1'b0, 4'h0, LIMIT, 32'h0, lat, done_c, flt);
    chk("limit_no_fault", flt, 1'b0);
    chk("limit_latency", lat, 3);

    // Reset in the middle of a debug access.
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access_mem_en", mem_en, 1'b1);
    snap = dbg_rdy_cnt;
    @(posedge clk); #1;
    reset = 1'b1; dbg_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_mem_en", mem_en, 1'b0);
    chk("post_reset_mem_we", mem_we, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_reset_no_ready", dbg_rdy_cnt - snap, 0);
    dbg_txn(1'b0, 32'h100, 32'h0, lat, done_d);
    chk("fresh_dbg_latency", lat, 3);
    chk("fresh_dbg_rdata", dbg_rdata, 32'h1234AB33);

    // Randomized concurrent traffic.
    fork
      cpu_random(120);
      dbg_random(120);
    join
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
